// File: rtl/lieat_exu_oitf_pkg.sv
// Shared definitions for the outstanding instruction track FIFO:
// pipe encodings, register index width and the entry record.
package lieat_exu_oitf_pkg;

   localparam int RGIDX_SIZE = 5;

   localparam logic [1:0] OITF_OP_LSU    = 2'b00;
   localparam logic [1:0] OITF_OP_MULDIV = 2'b01;
   localparam logic [1:0] OITF_OP_NONE   = 2'b11;

   typedef struct packed {
      logic [1:0]            op;
      logic                  wen;
      logic [RGIDX_SIZE-1:0] rd;
   } oitf_entry_t;

   // An entry hits a query only when it is live and actually writes rd.
   function automatic logic rd_hit(input oitf_entry_t e, input logic vld,
                                   input logic en, input logic [RGIDX_SIZE-1:0] idx);
      return vld & e.wen & en & (e.rd == idx);
   endfunction

endpackage

// File: rtl/lieat_exu_oitf_if.sv
// Dispatch, retire, hazard-query and status bundle between the execute
// stage (master) and the OITF (slave).
interface lieat_exu_oitf_if
   import lieat_exu_oitf_pkg::*;
#(
   parameter int DEPTH = 4
);
   localparam int PTR_W = $clog2(DEPTH);

   logic                  disp_valid;
   logic                  disp_ready;
   logic [1:0]            disp_op;
   logic                  disp_rdwen;
   logic [RGIDX_SIZE-1:0] disp_rd;

   logic                  ret_valid;
   logic [1:0]            ret_op;

   logic                  q_rs1en;
   logic                  q_rs2en;
   logic                  q_rdwen;
   logic [RGIDX_SIZE-1:0] q_rs1;
   logic [RGIDX_SIZE-1:0] q_rs2;
   logic [RGIDX_SIZE-1:0] q_rd;

   logic                  raw_dep;
   logic                  waw_dep;
   logic                  oitf_empty;
   logic                  oitf_full;
   logic [PTR_W:0]        oitf_cnt;
   logic                  ret_err;

   modport master (
      output disp_valid, disp_op, disp_rdwen, disp_rd,
      output ret_valid, ret_op,
      output q_rs1en, q_rs2en, q_rdwen, q_rs1, q_rs2, q_rd,
      input  disp_ready, raw_dep, waw_dep, oitf_empty, oitf_full, oitf_cnt, ret_err
   );

   modport slave (
      input  disp_valid, disp_op, disp_rdwen, disp_rd,
      input  ret_valid, ret_op,
      input  q_rs1en, q_rs2en, q_rdwen, q_rs1, q_rs2, q_rd,
      output disp_ready, raw_dep, waw_dep, oitf_empty, oitf_full, oitf_cnt, ret_err
   );

endinterface

// File: rtl/lieat_exu_oitf_oldest_match.sv
// Circular first-set-bit finder: one-hot select of the first match at or
// after the start pointer, via rotate / isolate lowest bit / rotate back.
module lieat_oitf_oldest_match #(
   parameter int DEPTH = 4,
   parameter int PTR_W = $clog2(DEPTH)
) (
   input  logic [DEPTH-1:0] match,
   input  logic [PTR_W-1:0] start,
   output logic [DEPTH-1:0] sel,
   output logic             none
);

   logic [2*DEPTH-1:0] rot_dbl;
   logic [2*DEPTH-1:0] back_dbl;
   logic [DEPTH-1:0]   rot;
   logic [DEPTH-1:0]   rot_oh;

   // Doubling the vector turns the rotate into a plain shift.
   assign rot_dbl  = {match, match} >> start;
   assign rot      = rot_dbl[DEPTH-1:0];
   assign rot_oh   = rot & (~rot + DEPTH'(1));
   assign back_dbl = {rot_oh, rot_oh} << start;
   assign sel      = back_dbl[2*DEPTH-1:DEPTH];
   assign none     = ~|match;

endmodule

// File: rtl/lieat_general_dfflr.sv
// Generic load-enabled flop with synchronous active-high clear.
module lieat_general_dfflr #(
   parameter int DW = 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          lden,
   input  logic [DW-1:0] dnxt,
   output logic [DW-1:0] qout
);

   always_ff @(posedge clk) begin
      if (rst)
         qout <= '0;
      else if (lden)
         qout <= dnxt;
   end

endmodule

// File: rtl/lieat_exu_oitf.sv
// Outstanding instruction track FIFO: tracks long-latency instructions from
// dispatch to writeback and answers RAW/WAW hazard queries at dispatch.
module lieat_exu_oitf
   import lieat_exu_oitf_pkg::*;
#(
   parameter  int DEPTH = 4,
   localparam int PTR_W = $clog2(DEPTH)
) (
   input  logic                 clk,
   input  logic                 rst,
   lieat_exu_oitf_if.slave      io
);

   logic [DEPTH-1:0] vld;
   oitf_entry_t      ent [DEPTH];
   oitf_entry_t      ent_nxt;
   logic [PTR_W-1:0] wptr;
   logic             ret_err_q;

   logic             disp_ready;
   logic             disp_hsk;
   logic             ret_qual;
   logic [DEPTH-1:0] match_vec;
   logic [DEPTH-1:0] ret_sel;
   logic             ret_none;
   logic [DEPTH-1:0] alloc;
   logic [DEPTH-1:0] clr;

   // Readiness looks only at the slot under wptr; holes elsewhere wait for wrap.
   assign disp_ready = ~vld[wptr];
   assign disp_hsk   = io.disp_valid & disp_ready;
   assign ret_qual   = io.ret_valid & (io.ret_op != OITF_OP_NONE);

   assign ent_nxt.op  = io.disp_op;
   assign ent_nxt.wen = io.disp_rdwen & (io.disp_rd != '0);
   assign ent_nxt.rd  = io.disp_rd;

   always_comb begin
      match_vec = '0;
      alloc     = '0;
      clr       = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_vec[i] = vld[i] & (ent[i].op == io.ret_op);
         alloc[i]     = disp_hsk & (wptr == PTR_W'(i));
         clr[i]       = ret_qual & ret_sel[i];
      end
   end

   // Scan starts at wptr, which is always the oldest slot in circular order.
   lieat_oitf_oldest_match #(
      .DEPTH (DEPTH),
      .PTR_W (PTR_W)
   ) u_oldest (
      .match (match_vec),
      .start (wptr),
      .sel   (ret_sel),
      .none  (ret_none)
   );

   for (genvar i = 0; i < DEPTH; i++) begin : g_ent
      // An allocated slot was empty, so alloc and clr never hit the same entry.
      lieat_general_dfflr #(.DW(1)) u_vld (
         .clk  (clk),
         .rst  (rst),
         .lden (alloc[i] | clr[i]),
         .dnxt (alloc[i]),
         .qout (vld[i])
      );

      lieat_general_dfflr #(.DW($bits(oitf_entry_t))) u_ent (
         .clk  (clk),
         .rst  (rst),
         .lden (alloc[i]),
         .dnxt (ent_nxt),
         .qout (ent[i])
      );
   end

   lieat_general_dfflr #(.DW(PTR_W)) u_wptr (
      .clk  (clk),
      .rst  (rst),
      .lden (disp_hsk),
      .dnxt (wptr + PTR_W'(1)),
      .qout (wptr)
   );

   lieat_general_dfflr #(.DW(1)) u_ret_err (
      .clk  (clk),
      .rst  (rst),
      .lden (ret_qual & ret_none),
      .dnxt (1'b1),
      .qout (ret_err_q)
   );

   logic           raw_dep;
   logic           waw_dep;
   logic [PTR_W:0] cnt;

   always_comb begin
      raw_dep = 1'b0;
      waw_dep = 1'b0;
      cnt     = '0;
      for (int i = 0; i < DEPTH; i++) begin
         raw_dep = raw_dep
                 | rd_hit(ent[i], vld[i], io.q_rs1en, io.q_rs1)
                 | rd_hit(ent[i], vld[i], io.q_rs2en, io.q_rs2);
         waw_dep = waw_dep | rd_hit(ent[i], vld[i], io.q_rdwen, io.q_rd);
         cnt     = cnt + (PTR_W+1)'(vld[i]);
      end
   end

   assign io.disp_ready = disp_ready;
   assign io.raw_dep    = raw_dep;
   assign io.waw_dep    = waw_dep;
   assign io.oitf_empty = ~|vld;
   assign io.oitf_full  = &vld;
   assign io.oitf_cnt   = cnt;
   assign io.ret_err    = ret_err_q;

endmodule

// File: doc/lieat_exu_oitf.md
# lieat_exu_oitf

Outstanding Instruction Track FIFO for the execute stage. Records every dispatched long-latency instruction (LSU load/store, MUL/DIV) until its result is written back. Answers RAW/WAW hazard queries for the instruction at dispatch, and drives the `oitf_waw_dep` input of the writeback arbiter. Retirement is driven by the arbiter's `longi_wbck`/`longi_wbck_op` outputs.

## Interface
Parameters:
- `DEPTH`, 4: number of entries; power of two, ≥2.
- `PTR_W`, `$clog2(DEPTH)`: pointer width; derived, not overridden.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  clock; all state updates on rising edge.
- `rst`  in  1  synchronous active-high reset.
- `disp_valid`  in  1  long-latency instruction dispatch request.
- `disp_ready`  out  1  entry available; allocation occurs on `disp_valid & disp_ready`.
- `disp_op`  in  2  `OITF_OP_LSU`=2'b00, `OITF_OP_MULDIV`=2'b01.
- `disp_rdwen`  in  1  instruction writes `rd`.
- `disp_rd`  in  `RGIDX_SIZE`  destination register.
- `ret_valid`  in  1  long writeback completing (`longi_wbck`).
- `ret_op`  in  2  retiring pipe (`longi_wbck_op`); 2'b11 = no retire.
- `q_rs1en`, `q_rs2en`, `q_rdwen`  in  1 each  query enables.
- `q_rs1`, `q_rs2`, `q_rd`  in  `RGIDX_SIZE` each  query register indices.
- `raw_dep`  out  1  rs1 or rs2 matches an outstanding destination.
- `waw_dep`  out  1  rd matches an outstanding destination (to WBU `oitf_waw_dep`).
- `oitf_empty`  out  1  no valid entries.
- `oitf_full`  out  1  all entries valid.
- `oitf_cnt`  out  `PTR_W+1`  number of valid entries.
- `ret_err`  out  1  sticky: retire with no matching entry.

## Operation
- Per entry state: `vld`, `op[1:0]`, `wen`, `rd`. Allocation pointer `wptr`.
- Allocate: `disp_ready = ~vld[wptr]`. On handshake, the entry at `wptr` is written with `vld=1`, `op`, `wen = disp_rdwen & (disp_rd != 0)`, `rd`. `wptr` increments mod DEPTH.
- Retire: when `ret_valid & ret_op != 2'b11`, scan entries circularly starting at `wptr`. The first valid entry with `op == ret_op` is the oldest match; clear its `vld`. Each pipe retires in order, but the two pipes retire out of order relative to each other.
- No match on a qualifying retire: no state change; set `ret_err` until reset.
- Hazards are combinational from registered entries only; there is no bypass of same-cycle dispatch or retire.
  - `raw_dep = OR over valid entries with wen: (q_rs1en & rd==q_rs1) | (q_rs2en & rd==q_rs2)`.
  - `waw_dep = OR over valid wen entries: q_rdwen & rd==q_rd`.
  - Register x0 never matches, because `wen` is cleared for x0 at allocation.
- Same-cycle dispatch and retire: both take effect. Dispatch readiness uses the pre-retire `vld[wptr]`, so a full FIFO does not accept dispatch in the cycle it retires.
- A freed entry that is not at `wptr` (a hole) is reused only when `wptr` wraps to it. `disp_ready` depends solely on `vld[wptr]`.
- `oitf_cnt` = popcount(`vld`). `oitf_full = &vld`. `oitf_empty = ~|vld`.

## Timing
- Reset values: all `vld`=0, `wptr`=0, `ret_err`=0. Hence `disp_ready`=1, `oitf_empty`=1, `oitf_full`=0, `oitf_cnt`=0, `raw_dep`=`waw_dep`=0.
- Reset asserted mid-operation discards all entries at the next edge; pending retires are lost.
- Allocation and retirement are visible in the outputs the cycle after the handshake edge (1-cycle latency).
- `disp_ready`, hazard outputs and status outputs have no combinational path from `disp_*` or `ret_*`.
- `wptr` wraps from DEPTH-1 to 0.

## Structure
- Shared defines file holds `OITF_OP_LSU`, `OITF_OP_MULDIV`, `OITF_OP_NONE` (2'b11) and reuses `RGIDX_SIZE`.
- Registers are built from `lieat_general_dfflr` instances with `rst` as the reset.
- One sub-module: `lieat_oitf_oldest_match`.
  - Inputs: a DEPTH-bit match vector and the start pointer.
  - Output: one-hot select of the first set bit at or after the start pointer (rotate, priority-encode, rotate back).
  - Also outputs a `none` flag.

## Test plan
- After reset: `disp_ready`=1, `oitf_empty`=1, `oitf_cnt`=0, `raw_dep`=0, `waw_dep`=0.
- Dispatch LSU rd=5, then query `q_rs1=5 q_rs1en=1` → `raw_dep`=1 next cycle. Retire `ret_op`=00 → `raw_dep`=0, `oitf_empty`=1.
- Dispatch MULDIV rd=3, LSU rd=7, MULDIV rd=3, then retire op 01 → entry 0 cleared. `waw_dep` for `q_rd=3` stays 1 and clears only after a second op-01 retire.
- Fill DEPTH=4 entries → `oitf_full`=1, `disp_ready`=0. Retire and `disp_valid` in the same cycle → no allocation. The next cycle allocates into the freed `wptr` entry only if it is the hole at `wptr`.
- Dispatch `rdwen`=1 with rd=0 → `waw_dep`=0 and `raw_dep`=0 for any query of x0; `oitf_cnt`=1.
- Retire op 01 with only LSU entries present → `ret_err`=1 (sticky), `oitf_cnt` unchanged. Apply `rst` → `ret_err`=0.
